// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB.
// Latches the EX payload and waits for the DCache data_ok of any request issued in EX.
// It holds the returned word if WB stalls, and forwards the raw read data to WB.
// Responses that belong to flushed instructions are counted and discarded.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   es_to_ms_valid/es_to_ms_bus   EX -> MEM handshake and payload (bit 118 = req_sent)
//   ms_allowin                    MEM can accept from EX this cycle
//   ws_allowin                    WB can accept
//   ms_to_ws_valid/ms_to_ws_bus   MEM -> WB handshake and payload
//   data_data_ok/data_rdata       DCache response strobe and read data
//   ms_flush                      kill MEM contents this cycle
//   MEM_dest/MEM_result           forwarding info for ID
//   ms_load_block                 resident load: ID must stall on RAW to MEM_dest

package mem_stage_pkg;

  // EX -> MEM payload, MSB first
  typedef struct packed {
    logic        req_sent;
    logic        res_from_mem;
    logic [11:0] mem_inst;
    logic [31:0] rt_value;
    logic [1:0]  rdata_type;
    logic        ex;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

  // MEM -> WB payload, MSB first
  typedef struct packed {
    logic        res_from_mem;
    logic [11:0] mem_inst;
    logic [31:0] rt_value;
    logic [31:0] data_rdata;
    logic [1:0]  rdata_type;
    logic        ex;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ES_TO_MS_BUS_WD = 119,
  parameter int unsigned MS_TO_WS_BUS_WD = 150,
  parameter int unsigned DROP_CNT_WD     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_data_ok,
  input  logic [31:0]                data_rdata,
  input  logic                       ms_flush,
  output logic [4:0]                 MEM_dest,
  output logic [31:0]                MEM_result,
  output logic                       ms_load_block
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DROP_CNT_WD-1:0] DROP_MAX = '1;
  localparam logic [DROP_CNT_WD-1:0] DROP_ONE = DROP_CNT_WD'(1);

  logic                   ms_valid_q,  ms_valid_d;
  es_to_ms_t              bus_q,       bus_d;
  logic [1:0]             state_q,     state_d;
  logic [31:0]            rdata_buf_q, rdata_buf_d;
  logic [DROP_CNT_WD-1:0] drop_cnt_q,  drop_cnt_d;

  es_to_ms_t es_in;
  ms_to_ws_t ws_out;
  logic      ms_ready_go;
  logic      drop_ok;
  logic      cur_ok;
  logic      drop_inc;

  assign es_in = es_to_ms_bus;

  // Response classification: orphans are retired before the resident instruction sees any ok
  always_comb begin
    drop_ok     = data_data_ok & (drop_cnt_q != '0);
    cur_ok      = data_data_ok & (drop_cnt_q == '0) & (state_q == S_WAIT);
    ms_ready_go = 1'b1;
    if (state_q == S_WAIT) begin
      ms_ready_go = cur_ok;
    end
  end

  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ms_flush;

  // Next-state logic for valid, payload, response FSM, hold buffer and discard counter
  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    drop_cnt_d  = drop_cnt_q;

    // A flushed instruction still waiting for its own ok leaves that ok orphaned
    drop_inc = ms_flush & ms_valid_q & (state_q == S_WAIT) & ~cur_ok;

    if (es_to_ms_valid & ms_allowin) begin
      bus_d = es_in;
    end

    if (ms_flush) begin
      ms_valid_d = 1'b0;
      state_d    = S_IDLE;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
      state_d    = (es_to_ms_valid & es_in.req_sent) ? S_WAIT : S_IDLE;
    end else if (cur_ok) begin
      // WB is stalled: park the word until it is taken
      rdata_buf_d = data_rdata;
      state_d     = S_DONE;
    end

    unique case ({drop_inc, drop_ok})
      2'b10: if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DROP_ONE;
      2'b01: drop_cnt_d = drop_cnt_q - DROP_ONE;
      default: drop_cnt_d = drop_cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      state_q     <= S_IDLE;
      rdata_buf_q <= 32'd0;
      drop_cnt_q  <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // WB payload: read data passes straight through in WAIT, comes from the buffer in DONE
  always_comb begin
    ws_out.res_from_mem = bus_q.res_from_mem;
    ws_out.mem_inst     = bus_q.mem_inst;
    ws_out.rt_value     = bus_q.rt_value;
    ws_out.rdata_type   = bus_q.rdata_type;
    ws_out.ex           = bus_q.ex;
    ws_out.gr_we        = bus_q.gr_we;
    ws_out.dest         = bus_q.dest;
    ws_out.result       = bus_q.result;
    ws_out.pc           = bus_q.pc;
    ws_out.data_rdata   = 32'd0;
    if (bus_q.req_sent) begin
      ws_out.data_rdata = (state_q == S_DONE) ? rdata_buf_q : data_rdata;
    end
  end

  assign ms_to_ws_bus  = ws_out;
  assign MEM_dest      = (ms_valid_q & bus_q.gr_we) ? bus_q.dest : 5'd0;
  assign MEM_result    = bus_q.result;
  assign ms_load_block = ms_valid_q & bus_q.res_from_mem;

  // More orphans than the counter can track means the DCache protocol was broken
  drop_cnt_not_saturated: assert property (@(posedge clk) disable iff (reset)
    drop_cnt_q != DROP_MAX);

endmodule
